// File: rtl/key_debounce_if.sv
// Pin-side and control-pulse signals of the push-button debouncer.
// The slave modport is the debouncer; the master modport is whoever drives the pin and consumes the pulses.
interface key_debounce_if;
    logic key;
    logic key_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    modport slave (
        input  key,
        output key_level,
        output press_pulse,
        output release_pulse,
        output long_pulse
    );

    modport master (
        output key,
        input  key_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button synchroniser and debouncer producing a clean level plus press/release/long-press strobes.
// Long-press detection (hold counter and long_pulse) is built only when KEY_LONG_PRESS_EN is defined.
//
//   state        | meaning
//   IDLE         | key released and stable
//   PRESS_WAIT   | key went low, qualifying the press
//   PRESSED      | press accepted, key held
//   RELEASE_WAIT | key went high, qualifying the release
module key_debounce #(
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned DEB_CYCLES  = 1_000_000,
    parameter int unsigned LONG_CYCLES = 2_000_000
) (
    input  logic           clk,
    input  logic           rst,
    key_debounce_if.slave  bus
);

    if (CNT_W < 2 || CNT_W > 31 || DEB_CYCLES < 2 || LONG_CYCLES < 2 ||
        64'(DEB_CYCLES) >= (64'd1 << CNT_W) ||
        64'(LONG_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_param
        $error("key_debounce: parameters out of range");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    state_t             state_q, state_d;
    logic               s1_q, s2_q;
    logic [CNT_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               key_sync;

`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               long_q, long_d;
`endif

    assign key_sync = s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            s1_q      <= bus.key;
            s2_q      <= s1_q;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!key_sync) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_sync) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
`ifdef KEY_LONG_PRESS_EN
                    hold_cnt_d = '0;
`endif
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (key_sync) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
`ifdef KEY_LONG_PRESS_EN
                else begin
                    // Saturating at LONG_CYCLES is what limits long_pulse to once per press.
                    if (hold_cnt_q != LONG_MAX) begin
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                    end
                    if (hold_cnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                    end
                end
`endif
            end
            RELEASE_WAIT: begin
                // A bounce back to low resumes the press; hold_cnt stays frozen meanwhile.
                if (!key_sync) begin
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.key_level     = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
`ifdef KEY_LONG_PRESS_EN
    assign bus.long_pulse    = long_q;
`else
    assign bus.long_pulse    = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with DEB_CYCLES=4, LONG_CYCLES=10, CNT_W=4 and a 100 ns clock.
// Expected outputs per edge come from a segment table written from the documented latencies.
module tb_key_debounce;

    localparam int CNT_W = 4;
    localparam int DEB   = 4;
    localparam int LONG  = 10;
`ifdef KEY_LONG_PRESS_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    key_debounce_if bus_if ();

    key_debounce #(
        .CNT_W       (CNT_W),
        .DEB_CYCLES  (DEB),
        .LONG_CYCLES (LONG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #50 clk = ~clk;

    typedef struct {
        logic r;
        logic k;
        int   n;
        logic lvl;
        logic prs;
        logic rel;
        logic lng;
    } vec_t;

    typedef struct {
        logic lvl;
        logic prs;
        logic rel;
        logic lng;
        int   edge_n;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    task automatic add(input logic r, input logic k, input int n,
                       input logic lvl, input logic prs, input logic rel, input logic lng);
        vec_t v;
        v = '{r, k, n, lvl, prs, rel, lng};
        vecs.push_back(v);
    endtask

    task automatic check1(input string name, input logic act, input logic exp_v, input int e);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, e, act, exp_v);
        end
    endtask

    // Drive before an edge, push the expectation, then pop and compare 1 ns after the edge.
    task automatic step(input logic r, input logic k,
                        input logic lvl, input logic prs, input logic rel, input logic lng);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus_if.key = k;
        e = '{lvl, prs, rel, lng, edge_n + 1};
        sb.push_back(e);
        @(posedge clk);
        #1;
        edge_n++;
        e = sb.pop_front();
        check1("key_level",     bus_if.key_level,     e.lvl, e.edge_n);
        check1("press_pulse",   bus_if.press_pulse,   e.prs, e.edge_n);
        check1("release_pulse", bus_if.release_pulse, e.rel, e.edge_n);
        check1("long_pulse",    bus_if.long_pulse,    e.lng, e.edge_n);
        checks++;
        if ((32'(bus_if.press_pulse) + 32'(bus_if.release_pulse) + 32'(bus_if.long_pulse)) > 1) begin
            errors++;
            $display("FAIL pulse_exclusive at edge %0d: got %b%b%b expected at most one high",
                     e.edge_n, bus_if.press_pulse, bus_if.release_pulse, bus_if.long_pulse);
        end
    endtask

    initial begin
        #(20_000 * 100);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus_if.key = 1'b1;

        // reset state
        add(1, 1, 2,  0, 0, 0, 0);
        // clean press held 36 edges: press at edge 7, long 10 edges later
        add(0, 0, 6,  0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 9,  1, 0, 0, 0);
        add(0, 0, 1,  1, 0, 0, LP);
        add(0, 0, 19, 1, 0, 0, 0);
        // clean release
        add(0, 1, 6,  1, 0, 0, 0);
        add(0, 1, 1,  0, 0, 1, 0);
        add(0, 1, 3,  0, 0, 0, 0);
        // bounce: low 3, high 2, then steady low; press 7 edges after final fall
        add(0, 0, 3,  0, 0, 0, 0);
        add(0, 1, 2,  0, 0, 0, 0);
        add(0, 0, 6,  0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 0, 0);
        add(0, 0, 3,  1, 0, 0, 0);
        // reset while PRESSED with key held, then re-qualification
        add(1, 0, 1,  0, 0, 0, 0);
        add(0, 0, 6,  0, 0, 0, 0);
        add(0, 0, 1,  1, 1, 0, 0);
        // release glitch returns to PRESSED without pulses, then real release
        add(0, 1, 3,  1, 0, 0, 0);
        add(0, 0, 4,  1, 0, 0, 0);
        add(0, 1, 6,  1, 0, 0, 0);
        add(0, 1, 1,  0, 0, 1, 0);
        add(0, 1, 2,  0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < vecs[i].n; j++) begin
                step(vecs[i].r, vecs[i].k, vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lng);
            end
        end

        // Reset on the very edge a press would be accepted drops that press.
        for (int j = 0; j < 6; j++) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 0, 0);

        // Reset on the long-press edge drops the long pulse; re-press then holds past it.
        for (int j = 0; j < 6; j++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        for (int j = 0; j < 9; j++) step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 6; j++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        // glitch after the long pulse must not re-fire it when hold resumes
        for (int j = 0; j < 9; j++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, LP);
        for (int j = 0; j < 3; j++) step(0, 1, 1, 0, 0, 0);
        for (int j = 0; j < 15; j++) step(0, 0, 1, 0, 0, 0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
